// File: rtl/soc_periph_req_arbiter.sv
// soc_periph_req_arbiter: round-robin sharing of one peripheral port with ariane_soc address decode and local error/timeout responses
module soc_periph_req_arbiter #(
  parameter int unsigned NR_MASTERS = 3,
  parameter int unsigned ADDR_W     = 64,
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [NR_MASTERS-1:0]             m_req_i,
  input  logic [NR_MASTERS-1:0]             m_we_i,
  input  logic [NR_MASTERS-1:0][ADDR_W-1:0] m_addr_i,
  input  logic [NR_MASTERS-1:0][DATA_W-1:0] m_wdata_i,
  output logic [NR_MASTERS-1:0]             m_gnt_o,
  output logic [NR_MASTERS-1:0]             m_rvalid_o,
  output logic [DATA_W-1:0]                 m_rdata_o,
  output logic                              m_err_o,
  output logic                              s_req_o,
  output logic                              s_we_o,
  output logic [ADDR_W-1:0]                 s_addr_o,
  output logic [DATA_W-1:0]                 s_wdata_o,
  output logic [9:0]                        s_sel_o,
  input  logic                              s_gnt_i,
  input  logic                              s_rvalid_i,
  input  logic [DATA_W-1:0]                 s_rdata_i,
  input  logic                              s_err_i,
  output logic                              busy_o,
  output logic                              timeout_o
);
  localparam int unsigned PW = NR_MASTERS > 1 ? $clog2(NR_MASTERS) : 1;
  localparam int unsigned CW = $clog2(TIMEOUT);
  // index order follows axi_slaves_t: Debug(9) .. DRAM(0)
  localparam logic [9:0][63:0] BASE = {
    64'h0000_0000, 64'h0001_0000, 64'h0200_0000, 64'h0C00_0000, 64'h1000_0000,
    64'h1800_0000, 64'h2000_0000, 64'h3000_0000, 64'h4000_0000, 64'h8000_0000};
  localparam logic [9:0][63:0] LEN = {
    64'h0000_1000, 64'h0001_0000, 64'h000C_0000, 64'h03FF_FFFF, 64'h0000_1000,
    64'h0000_1000, 64'h0080_0000, 64'h0001_0000, 64'h0000_1000, 64'h4000_0000};
  typedef enum logic [1:0] {IDLE, REQ, RESP, ERR} state_e;
  state_e                  state_q, state_d;
  logic [PW-1:0]           ptr_q, ptr_d, w_q, win;
  logic                    found, done, expire;
  logic [ADDR_W-1:0]       addr, addr_q;
  logic [9:0]              sel, sel_q;
  logic [CW-1:0]           cnt_q;
  logic                    we_q, err_q, tmo_q;
  logic [DATA_W-1:0]       wdata_q, rdata_q;
  logic [NR_MASTERS-1:0]   rvalid_q;
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int i = 0; i < NR_MASTERS; i++) begin
      if (!found && m_req_i[(int'(ptr_q) + i) % NR_MASTERS]) begin
        found = 1'b1;
        win   = PW'((int'(ptr_q) + i) % NR_MASTERS);
      end
    end
    ptr_d = PW'((int'(win) + 1) % NR_MASTERS);
    addr  = m_addr_i[win];
    for (int k = 0; k < 10; k++)
      sel[k] = addr >= ADDR_W'(BASE[k]) && addr < ADDR_W'(BASE[k]) + ADDR_W'(LEN[k]);
  end
  assign done   = (state_q == REQ && s_gnt_i && s_rvalid_i) || (state_q == RESP && s_rvalid_i);
  assign expire = (state_q == REQ || state_q == RESP) && !done && cnt_q == CW'(TIMEOUT - 1);
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = found ? (|sel ? REQ : ERR) : IDLE;
      REQ:     state_d = done ? IDLE : expire ? ERR : s_gnt_i ? RESP : REQ;
      RESP:    state_d = done ? IDLE : expire ? ERR : RESP;
      default: state_d = IDLE;
    endcase
  end
  // grant is gated by reset so nothing leaks out while rst_ni is low
  always_comb begin
    m_gnt_o = (state_q == IDLE && rst_ni && found) ? NR_MASTERS'(1) << win : '0;
    s_req_o = state_q == REQ;
    busy_o  = state_q != IDLE;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q    <= '0;
      w_q      <= '0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      sel_q    <= '0;
      cnt_q    <= '0;
      rvalid_q <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      cnt_q <= state_q == IDLE ? '0 : cnt_q + CW'(1);
      if (state_q == IDLE && found) begin
        w_q     <= win;
        ptr_q   <= ptr_d;
        addr_q  <= addr;
        we_q    <= m_we_i[win];
        wdata_q <= m_wdata_i[win];
        sel_q   <= sel;
      end
      rvalid_q <= (done || state_q == ERR) ? NR_MASTERS'(1) << w_q : '0;
      rdata_q  <= done ? s_rdata_i : '0;
      err_q    <= done ? s_err_i : state_q == ERR;
      tmo_q    <= expire;
    end
  end
  assign m_rvalid_o = rvalid_q;
  assign m_rdata_o  = rdata_q;
  assign m_err_o    = err_q;
  assign s_we_o     = we_q;
  assign s_addr_o   = addr_q;
  assign s_wdata_o  = wdata_q;
  assign s_sel_o    = sel_q;
  assign timeout_o  = tmo_q;
endmodule
